// File: rtl/axis_checker.sv
// AXI-stream sink: LFSR-throttled ready, checks an incrementing modulo-2^WIDTH sequence.
// Counters update one edge after the transfer edge; iready is a registered, pseudo-random gate.
module axis_checker #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             throttle,
  input  logic [WIDTH-1:0]       idata,
  input  logic                   ivalid,
  output logic                   iready,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0] errors,
  output logic                   error
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t           state, state_next;
  logic [15:0]      lfsr;
  logic [WIDTH-1:0] expected;
  logic             gate;
  logic             xfer;
  logic             mismatch;
  logic             acc_q;
  logic             mis_q;

  assign xfer = ivalid && iready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = SYNC;
      SYNC:    if (!enable) state_next = IDLE;
               else if (xfer) state_next = LOCKED;
      LOCKED:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mismatch = 1'b0;
    if (xfer && state == LOCKED && idata != expected) mismatch = 1'b1;
    case (throttle)
      2'd0:    gate = 1'b1;
      2'd1:    gate = (lfsr[1:0] != 2'b00);
      2'd2:    gate = lfsr[0];
      default: gate = (lfsr[1:0] == 2'b00);
    endcase
  end

  assign locked = (state == LOCKED);

  // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running regardless of traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr   <= 16'hACE1;
      iready <= 1'b0;
    end else begin
      lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      iready <= enable && gate;
    end
  end

  // Every transfer resyncs the expectation, so a single corrupted word costs two errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      expected <= '0;
      acc_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      acc_q <= xfer;
      mis_q <= mismatch;
      if (xfer) expected <= idata + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      errors <= '0;
      error  <= 1'b0;
    end else begin
      if (acc_q && count != '1) count <= count + 1'b1;
      if (mis_q) begin
        error <= 1'b1;
        if (errors != '1) errors <= errors + 1'b1;
      end
    end
  end

endmodule
